// File: rtl/stream_fork_eager_pkg.sv
// Shared constants, types and helpers for the stream_fork_eager block.
// The optional FORK_STATS_EN macro adds statistics counters to the top-level module.
package stream_fork_pkg;

  localparam int DATA_W_DEF  = 17;
  localparam int NUM_OUT_DEF = 9;
  localparam int DROP_CNT_W  = 16;
  localparam int STAT_CNT_W  = 32;

  typedef logic [DATA_W_DEF-1:0] stream_word_t;

  // Drop counter increment that holds at all-ones instead of wrapping
  function automatic logic [DROP_CNT_W-1:0] drop_sat_inc(input logic [DROP_CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

  // Stall counter increment that holds at all-ones instead of wrapping
  function automatic logic [STAT_CNT_W-1:0] stat_sat_inc(input logic [STAT_CNT_W-1:0] c);
    return (c == '1) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/stream_fork_eager_if.sv
// Handshake bundle for the eager fork. The upstream word, its route mask and
// valid/ready, plus the shared consumer data and per-consumer valid/ready.
// master = environment (producer and consumers); slave = the fork itself.
interface stream_fork_eager_if #(
  parameter int NUM_OUT = 9,
  parameter int DATA_W  = 17
);
  logic [DATA_W-1:0]  in_data;
  logic [NUM_OUT-1:0] in_sel;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  out_data;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;

  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/stream_fork_eager_done_tracker.sv
// Per-consumer bookkeeping for the eager fork: remembers which consumers a
// held token targets and which have already taken it, drives the per-consumer
// valids and tells the top when the last outstanding target has handshaked.
module fork_done_tracker #(
  parameter int NUM_OUT = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               accept,
  input  logic               full,
  input  logic [NUM_OUT-1:0] tgt,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [NUM_OUT-1:0] out_valid,
  output logic               retire
);

  logic [NUM_OUT-1:0] tgt_q;
  logic [NUM_OUT-1:0] done_q;

  assign out_valid = {NUM_OUT{full}} & tgt_q & ~done_q;
  // Retire when no target is left that is still owed the token and not ready now
  assign retire    = full & ((tgt_q & ~done_q & ~out_ready) == '0);

  // Freeze the target mask at accept and accumulate handshakes until retire
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tgt_q  <= '0;
      done_q <= '0;
    end else if (flush) begin
      done_q <= '0;
    end else if (accept) begin
      tgt_q  <= tgt;
      done_q <= '0;
    end else if (retire) begin
      done_q <= '0;
    end else begin
      done_q <= done_q | (out_valid & out_ready);
    end
  end

endmodule

// File: rtl/stream_fork_eager.sv
// Registered eager fork: holds one upstream token and hands it to each
// selected consumer independently; upstream is released only once every
// target has taken the token. Tokens whose target mask is empty are dropped
// and counted. Optional macro FORK_STATS_EN adds stall_cnt and tok_cnt.
module stream_fork_eager
  import stream_fork_pkg::*;
#(
  parameter int NUM_OUT = NUM_OUT_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [NUM_OUT-1:0]    cfg_en,
  stream_fork_eager_if.slave    bus,
  output logic [DROP_CNT_W-1:0] drop_cnt
`ifdef FORK_STATS_EN
  ,
  output logic [STAT_CNT_W-1:0] stall_cnt,
  output logic [STAT_CNT_W-1:0] tok_cnt
`endif
);

  logic               full;
  logic [DATA_W-1:0]  data_q;
  logic [NUM_OUT-1:0] tgt;
  logic               retire;
  logic               in_ready;
  logic               accept;

  assign tgt      = cfg_en & bus.in_sel;
  assign in_ready = rst_n & ~flush & (~full | retire);
  assign accept   = bus.in_valid & in_ready;

  assign bus.in_ready = in_ready;
  assign bus.out_data = data_q;

  fork_done_tracker #(
    .NUM_OUT (NUM_OUT)
  ) u_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .accept    (accept),
    .full      (full),
    .tgt       (tgt),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .retire    (retire)
  );

  // Token holding register: capture on accept, release on retire, drop empty-mask tokens
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full     <= 1'b0;
      data_q   <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      full <= 1'b0;
    end else if (accept) begin
      data_q <= bus.in_data;
      full   <= |tgt;
      if (tgt == '0) begin
        drop_cnt <= drop_sat_inc(drop_cnt);
      end
    end else if (retire) begin
      full <= 1'b0;
    end
  end

`ifdef FORK_STATS_EN
  // Statistics: saturating stall cycles and wrapping retired-token count, kept across flush
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      tok_cnt   <= '0;
    end else begin
      if (full & ~retire) begin
        stall_cnt <= stat_sat_inc(stall_cnt);
      end
      if (retire & ~flush) begin
        tok_cnt <= tok_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_stream_fork_eager.sv
// Directed testbench for stream_fork_eager with hand-computed expectations.
// Covers the FORK_STATS_EN counters when that macro is defined.
module tb_stream_fork_eager;
  import stream_fork_pkg::*;

  localparam int NO = 9;
  localparam int DW = 17;

  logic          clk;
  logic          rst_n;
  logic          flush;
  logic [NO-1:0] cfg_en;
  logic [15:0]   drop_cnt;
`ifdef FORK_STATS_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   tok_cnt;
`endif

  int compared;
  int mismatched;

  stream_fork_eager_if #(.NUM_OUT(NO), .DATA_W(DW)) bus ();

  stream_fork_eager #(.NUM_OUT(NO), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .cfg_en    (cfg_en),
    .bus       (bus.slave),
    .drop_cnt  (drop_cnt)
`ifdef FORK_STATS_EN
    ,
    .stall_cnt (stall_cnt),
    .tok_cnt   (tok_cnt)
`endif
  );

  // Free-running 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and record the result
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive upstream and consumer-side inputs, then let combinational logic settle
  task automatic applyStimulus(input logic valid, input logic [DW-1:0] data,
                               input logic [NO-1:0] sel, input logic [NO-1:0] rdy);
    bus.in_valid  = valid;
    bus.in_data   = data;
    bus.in_sel    = sel;
    bus.out_ready = rdy;
    #1;
  endtask

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int errs;
    logic [DW-1:0] prev;
    stream_word_t  w;

    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    flush      = 1'b0;
    cfg_en     = 9'h1FF;
    applyStimulus(1'b0, 17'h0, 9'h0, 9'h0);

    // Reset
    tick();
    tick();
    checkOutput("rst_in_ready_low", 32'(bus.in_ready), 32'h0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready_rel", 32'(bus.in_ready), 32'h1);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'h0);
    checkOutput("rst_drop_cnt", 32'(drop_cnt), 32'h0);

    // Single target
    applyStimulus(1'b1, 17'h0ABC, 9'h001, 9'h1FF);
    checkOutput("t1_in_ready_acc", 32'(bus.in_ready), 32'h1);
    tick();
    applyStimulus(1'b0, 17'h0, 9'h001, 9'h1FF);
    checkOutput("t1_out_valid", 32'(bus.out_valid), 32'h001);
    checkOutput("t1_out_data", 32'(bus.out_data), 32'h0ABC);
    checkOutput("t1_in_ready_hold", 32'(bus.in_ready), 32'h1);
    tick();
    checkOutput("t1_out_valid_done", 32'(bus.out_valid), 32'h0);

    // Staggered consumers
    applyStimulus(1'b1, 17'h1234, 9'h1FF, 9'h000);
    tick();
    applyStimulus(1'b0, 17'h0, 9'h1FF, 9'h00F);
    checkOutput("stg_c1_valid", 32'(bus.out_valid), 32'h1FF);
    checkOutput("stg_c1_ready", 32'(bus.in_ready), 32'h0);
    tick();
    applyStimulus(1'b0, 17'h0, 9'h1FF, 9'h000);
    checkOutput("stg_c2_valid", 32'(bus.out_valid), 32'h1F0);
    checkOutput("stg_c2_ready", 32'(bus.in_ready), 32'h0);
    tick();
    applyStimulus(1'b1, 17'h0555, 9'h002, 9'h1F0);
    checkOutput("stg_c3_valid", 32'(bus.out_valid), 32'h1F0);
    checkOutput("stg_c3_data", 32'(bus.out_data), 32'h1234);
    checkOutput("stg_c3_ready", 32'(bus.in_ready), 32'h1);
    tick();
    applyStimulus(1'b0, 17'h0, 9'h002, 9'h1FF);
    checkOutput("stg_next_valid", 32'(bus.out_valid), 32'h002);
    checkOutput("stg_next_data", 32'(bus.out_data), 32'h0555);
    tick();
    checkOutput("stg_idle_valid", 32'(bus.out_valid), 32'h0);
`ifdef FORK_STATS_EN
    checkOutput("stats_stall", stall_cnt, 32'd2);
`endif

    // Streaming 100 words with every consumer ready
    acc  = 0;
    errs = 0;
    prev = '0;
    for (int i = 0; i < 100; i++) begin
      w = stream_word_t'(32'h100 + i);
      applyStimulus(1'b1, w, 9'h1FF, 9'h1FF);
      if (bus.in_ready) acc++;
      if (i > 0 && (bus.out_data !== prev || bus.out_valid !== 9'h1FF)) errs++;
      prev = w;
      tick();
    end
    applyStimulus(1'b0, 17'h0, 9'h1FF, 9'h1FF);
    checkOutput("str_accepts", 32'(acc), 32'd100);
    checkOutput("str_data_errs", 32'(errs), 32'd0);
    checkOutput("str_last_data", 32'(bus.out_data), 32'h163);
    checkOutput("str_last_valid", 32'(bus.out_valid), 32'h1FF);
    tick();
    checkOutput("str_drained", 32'(bus.out_valid), 32'h0);
`ifdef FORK_STATS_EN
    checkOutput("stats_tok", tok_cnt, 32'd103);
`endif

    // Empty target mask is dropped and counted
    cfg_en = 9'h0F0;
    applyStimulus(1'b1, 17'h0777, 9'h00F, 9'h1FF);
    checkOutput("drop_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    applyStimulus(1'b0, 17'h0, 9'h00F, 9'h1FF);
    checkOutput("drop_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("drop_cnt_one", 32'(drop_cnt), 32'h1);
    checkOutput("drop_in_ready_after", 32'(bus.in_ready), 32'h1);

    // Mid-token config change is ignored
    cfg_en = 9'h1FF;
    applyStimulus(1'b1, 17'h0042, 9'h003, 9'h000);
    tick();
    cfg_en = 9'h000;
    applyStimulus(1'b0, 17'h0, 9'h000, 9'h000);
    checkOutput("cfg_hold_valid", 32'(bus.out_valid), 32'h003);
    tick();
    checkOutput("cfg_hold_valid2", 32'(bus.out_valid), 32'h003);
    checkOutput("cfg_hold_ready", 32'(bus.in_ready), 32'h0);
    applyStimulus(1'b0, 17'h0, 9'h000, 9'h001);
    tick();
    applyStimulus(1'b0, 17'h0, 9'h000, 9'h002);
    checkOutput("cfg_part_valid", 32'(bus.out_valid), 32'h002);
    checkOutput("cfg_part_data", 32'(bus.out_data), 32'h0042);
    tick();
    checkOutput("cfg_done_valid", 32'(bus.out_valid), 32'h0);

    // Flush while a token is partially delivered
    cfg_en = 9'h1FF;
    applyStimulus(1'b1, 17'h0099, 9'h00F, 9'h000);
    tick();
    applyStimulus(1'b0, 17'h0, 9'h00F, 9'h005);
    tick();
    applyStimulus(1'b0, 17'h0, 9'h00F, 9'h000);
    checkOutput("fl_pre_valid", 32'(bus.out_valid), 32'h00A);
    flush = 1'b1;
    #1;
    checkOutput("fl_in_ready_low", 32'(bus.in_ready), 32'h0);
    tick();
    flush = 1'b0;
    #1;
    checkOutput("fl_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("fl_in_ready", 32'(bus.in_ready), 32'h1);
    checkOutput("fl_drop_kept", 32'(drop_cnt), 32'h1);

    // Same sequence with reset instead of flush
    applyStimulus(1'b1, 17'h0099, 9'h00F, 9'h000);
    tick();
    applyStimulus(1'b0, 17'h0, 9'h00F, 9'h005);
    tick();
    applyStimulus(1'b0, 17'h0, 9'h00F, 9'h000);
    rst_n = 1'b0;
    #1;
    checkOutput("rs_in_ready_low", 32'(bus.in_ready), 32'h0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("rs_out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("rs_in_ready", 32'(bus.in_ready), 32'h1);
    checkOutput("rs_drop_cnt", 32'(drop_cnt), 32'h0);
    checkOutput("rs_out_data", 32'(bus.out_data), 32'h0);

    // Drop counter saturation: 65536 empty-mask tokens back to back
    cfg_en = 9'h000;
    applyStimulus(1'b1, 17'h0001, 9'h1FF, 9'h1FF);
    for (int i = 0; i < 65536; i++) begin
      tick();
    end
    checkOutput("drop_sat", 32'(drop_cnt), 32'h0000FFFF);
    checkOutput("drop_sat_ready", 32'(bus.in_ready), 32'h1);
    applyStimulus(1'b0, 17'h0, 9'h0, 9'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/stream_fork_eager.md
# stream_fork_eager

Registered eager fork for SAM coordinate/reference streams on the Onyx CGRA. It sits directly downstream of the combinational fanout-ready reduction and replaces its all-consumers-ready-together requirement. It latches one token and delivers it to each selected consumer independently, tracking per-consumer completion. Upstream sees ready only once every target has taken the token.

## Interface
Parameters:
- NUM_OUT, 9, number of consumer ports
- DATA_W, 17, stream word width (16-bit payload + 1 control/stop bit)

Ports:
- clk  input  1  clock
- rst_n  input  1  reset; one clock, synchronous, active-low
- flush  input  1  synchronous clear of held token and completion state
- cfg_en  input  NUM_OUT  static per-consumer enable
- in_data  input  DATA_W  upstream word
- in_sel  input  NUM_OUT  per-token route mask
- in_valid  input  1  upstream valid
- in_ready  output  1  upstream ready
- out_data  output  DATA_W  held word, shared by all consumers
- out_valid  output  NUM_OUT  per-consumer valid
- out_ready  input  NUM_OUT  per-consumer ready
- drop_cnt  output  16  tokens accepted with empty target mask, saturating

## Operation
- State: full (1 bit), data_q (DATA_W), tgt_q (NUM_OUT), done_q (NUM_OUT).
- Target mask `tgt = cfg_en & in_sel`, sampled at accept and frozen while the token is held. Changes to cfg_en or in_sel mid-token are ignored.
- `out_valid[i] = full & tgt_q[i] & ~done_q[i]`. `out_data = data_q`.
- Per-consumer handshake: `out_valid[i] & out_ready[i]` sets done_q[i].
- `retire = full & ((tgt_q & ~done_q & ~(out_ready)) == 0)`. The token retires in the cycle its last outstanding target handshakes. Targets that handshake in the same cycle all count.
- `in_ready = ~full | retire`.
- Accept (`in_valid & in_ready`):
  - data_q ← in_data, tgt_q ← tgt, done_q ← 0.
  - full ← 1 if tgt ≠ 0.
  - If tgt = 0: full ← 0 (token dropped), drop_cnt += 1, saturating at 0xFFFF.
- Retire without accept: full ← 0, done_q ← 0.
- flush (priority over accept and retire):
  - full ← 0, done_q ← 0.
  - in_ready is forced to 0 during flush.
  - drop_cnt is unaffected.
- Reset values: full 0, data_q 0, tgt_q 0, done_q 0, out_valid 0, out_data 0, in_ready 1 after reset release, drop_cnt 0. During rst_n low, in_ready = 0.

## Timing
- Latency: a token accepted in cycle N drives out_valid in cycle N+1.
- Throughput: 1 token/cycle when all targets are ready. Back-to-back accept is permitted in the retire cycle.
- in_ready depends combinationally on out_ready and registered state only, never on in_valid.
- out_valid and out_data are purely registered.
- Once out_valid[i] is asserted it stays high, with out_data stable, until consumer i handshakes, flush, or reset.
- Reset asserted mid-token: the token is discarded and no out_valid is seen on the next cycle.

## Configuration
- FORK_STATS_EN defined:
  - Adds output `stall_cnt` (32-bit, saturating): cycles with `full & ~retire`.
  - Adds output `tok_cnt` (32-bit, wrapping): retired tokens.
  - Both clear on reset; flush does not clear them.
- Undefined: neither port nor its logic exists. Core behaviour is identical.

## Structure
- Package `stream_fork_pkg`:
  - DATA_W default constant.
  - Typedef `stream_word_t` (logic [DATA_W-1:0]).
  - Counter width constants (16 drop, 32 stats).
- Sub-module `fork_done_tracker`: owns tgt_q/done_q, produces out_valid and retire. The top holds data_q, full, the accept logic and counters.

## Test plan
- Single target: cfg_en=all 1, in_sel=0x001, in_data=0x0ABC, out_ready=all 1 → out_valid=0x001 one cycle after accept, out_data=0x0ABC, in_ready stays 1.
- Staggered consumers: tgt=0x1FF, out_ready[0..3] high in cycle 1, [4..8] high in cycle 3 → out_valid 0x1FF → 0x1F0 → 0x1F0 → 0x000 after cycle 3. The next token is accepted in the cycle-3 retire.
- Streaming: 100 words, all ready → exactly 100 cycles, no bubbles. tok_cnt=100 with FORK_STATS_EN.
- Empty mask: cfg_en=0x0F0, in_sel=0x00F → no out_valid, drop_cnt=1, in_ready remains 1.
- Mid-token config change: hold a token with tgt=0x003, flip cfg_en to 0 → out_valid stays 0x003 until handshakes.
- Flush/reset: flush while done_q=0x005, tgt=0x00F → next cycle out_valid=0, in_ready=1. Same sequence with rst_n low gives identical outputs plus drop_cnt=0.
